jtag_player_arbiter: RTL and testbench

- Shares the byte-write port of the JTAG FIFO player between two requesters.
  - Requester A: host/register path.
  - Requester B: autonomous scan/config engine.
- Grants the player to one requester per complete stream, from first byte through a `last`-tagged byte, then waits for player completion.
- Reports done or error to the owner.
- On player error or completion timeout, pulses the player FIFO reset.
- Sits directly in front of the player's `data_in` / `write_enable_fifo` / `rst_fifo` inputs.

---
 rtl/jtag_player_pkg.sv | 24 ++
 rtl/jtag_player_arbiter_rr_arb2.sv | 48 ++++
 rtl/jtag_player_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_jtag_player_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_player_pkg.sv
// ---------------------------------------------------------------------------
// jtag_player_pkg
// Shared definitions for the JTAG FIFO player front end.
//   state_t             : arbiter state encoding (IDLE, STREAM, DRAIN, ABORT)
//   OWN_A / OWN_B       : owner encoding (0 = host path, 1 = scan engine)
//   DEFAULT_HIGH_WATER  : default accept limit on the player write count
//   FIFO_DEPTH          : depth of the player's byte FIFO
// ---------------------------------------------------------------------------
package jtag_player_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    localparam int FIFO_DEPTH         = 1024;
    localparam int DEFAULT_HIGH_WATER = 1016;

endpackage

// File: rtl/jtag_player_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. The grant is combinational from the requests;
// only the memory of who won last time is registered.
//   clk         : clock
//   rst         : synchronous active-high reset (rr_last <= OWN_B)
//   req_a/req_b : requests from A and B
//   take        : the grant is being used this cycle, remember the winner
//   grant_valid : at least one request present
//   grant_owner : winner (OWN_A / OWN_B)
// ---------------------------------------------------------------------------
module rr_arb2
    import jtag_player_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic grant_valid,
    output logic grant_owner
);

    logic rr_last;

    // A lone requester always wins; on a tie the one that did not win last
    // time gets the grant.
    always_comb begin
        grant_valid = req_a | req_b;
        if (req_a && req_b) begin
            grant_owner = ~rr_last;
        end else if (req_b) begin
            grant_owner = OWN_B;
        end else begin
            grant_owner = OWN_A;
        end
    end

    // Resetting to B makes A the winner of the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= OWN_B;
        end else if (take) begin
            rr_last <= grant_owner;
        end
    end

endmodule

// File: rtl/jtag_player_arbiter.sv
// ---------------------------------------------------------------------------
// jtag_player_arbiter
// Shares the JTAG FIFO player byte-write port between requester A (host
// path) and requester B (scan/config engine). One requester owns the player
// for a whole stream (through its last-tagged byte) and until the player
// reports completion; player errors or a completion timeout abort the
// stream and pulse the player FIFO reset.
//   clk_in, rst_in             : clock, synchronous active-high reset
//   a_* / b_*                  : byte request interfaces (data/valid/last in,
//                                ready/done/err out)
//   fifo_data, fifo_wr_en      : registered byte write into the player
//   fifo_rst                   : player FIFO reset
//   full_fifo, empty_fifo,
//   wr_data_count              : player FIFO status
//   eof_in, error_in           : player completion / error
//   busy, owner                : arbiter status
// ---------------------------------------------------------------------------
module jtag_player_arbiter
    import jtag_player_pkg::*;
#(
    parameter int HIGH_WATER    = DEFAULT_HIGH_WATER,
    parameter int DRAIN_TIMEOUT = 1048576,
    parameter int RST_CYCLES    = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    input  logic       a_last,
    output logic       a_ready,
    output logic       a_done,
    output logic       a_err,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    input  logic       b_last,
    output logic       b_ready,
    output logic       b_done,
    output logic       b_err,
    output logic [7:0] fifo_data,
    output logic       fifo_wr_en,
    output logic       fifo_rst,
    input  logic       full_fifo,
    input  logic       empty_fifo,
    input  logic [9:0] wr_data_count,
    input  logic       eof_in,
    input  logic       error_in,
    output logic       busy,
    output logic       owner
);

    localparam int TIMER_W = $clog2(DRAIN_TIMEOUT) + 1;
    localparam int RST_W   = $clog2(RST_CYCLES) + 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [9:0]         HW_LIMIT   = 10'(HIGH_WATER);

    state_t             state;
    logic               owner_q;
    logic [TIMER_W-1:0] drain_timer;
    logic [RST_W-1:0]   rst_count;

    logic       room;
    logic       accept_a;
    logic       accept_b;
    logic       accept;
    logic       accept_last;
    logic [7:0] accept_data;
    logic       grant_valid;
    logic       grant_owner;
    logic       grant_take;
    logic       abort_now;
    logic       unused_status;

    // The player's empty flag carries no information the arbiter needs.
    assign unused_status = empty_fifo;

    rr_arb2 u_rr_arb2 (
        .clk         (clk_in),
        .rst         (rst_in),
        .req_a       (a_valid),
        .req_b       (b_valid),
        .take        (grant_take),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign grant_take = (state == IDLE) && grant_valid && !rst_in;

    // Ready is combinational so a byte can be taken every cycle. It is gated
    // by rst_in so nothing slips into the FIFO during a reset cycle.
    assign room     = !full_fifo && (wr_data_count < HW_LIMIT);
    assign a_ready  = !rst_in && (state == STREAM) && (owner_q == OWN_A) && room;
    assign b_ready  = !rst_in && (state == STREAM) && (owner_q == OWN_B) && room;
    assign accept_a = a_ready && a_valid;
    assign accept_b = b_ready && b_valid;
    assign accept   = accept_a || accept_b;

    assign accept_data = accept_b ? b_data : a_data;
    assign accept_last = accept_b ? b_last : a_last;

    // An error in STREAM or DRAIN beats both eof and a last byte; a DRAIN
    // that runs out of time without eof is treated like an error.
    assign abort_now = ((state == STREAM) && error_in) ||
                       ((state == DRAIN) &&
                        (error_in || (!eof_in && (drain_timer == TIMER_LAST))));

    assign busy  = (state != IDLE);
    assign owner = owner_q;

    // Main FSM. The byte write path runs regardless of the state decision,
    // so a byte accepted in the same cycle as an error still reaches the
    // player. ABORT holds fifo_rst for RST_CYCLES cycles including the
    // entry cycle, then drops it as it returns to IDLE.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            owner_q     <= OWN_A;
            drain_timer <= '0;
            rst_count   <= '0;
            fifo_data   <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_rst    <= 1'b1;
            a_done      <= 1'b0;
            a_err       <= 1'b0;
            b_done      <= 1'b0;
            b_err       <= 1'b0;
        end else begin
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_data <= accept_data;
            end
            fifo_rst <= 1'b0;
            a_done   <= 1'b0;
            a_err    <= 1'b0;
            b_done   <= 1'b0;
            b_err    <= 1'b0;

            if (abort_now) begin
                state     <= ABORT;
                rst_count <= '0;
                fifo_rst  <= 1'b1;
                a_err     <= (owner_q == OWN_A);
                b_err     <= (owner_q == OWN_B);
            end else begin
                case (state)
                    IDLE: begin
                        if (grant_valid) begin
                            state   <= STREAM;
                            owner_q <= grant_owner;
                        end
                    end
                    STREAM: begin
                        if (accept && accept_last) begin
                            state       <= DRAIN;
                            drain_timer <= '0;
                        end
                    end
                    DRAIN: begin
                        if (eof_in) begin
                            state  <= IDLE;
                            a_done <= (owner_q == OWN_A);
                            b_done <= (owner_q == OWN_B);
                        end else if (drain_timer != TIMER_MAX) begin
                            drain_timer <= drain_timer + 1'b1;
                        end
                    end
                    ABORT: begin
                        if (rst_count == RST_LAST) begin
                            state <= IDLE;
                        end else begin
                            rst_count <= rst_count + 1'b1;
                            fifo_rst  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_player_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jtag_player_arbiter
// Directed scenarios followed by a randomized run. Each requester is a
// queue of bytes; the environment (FIFO status, eof, error, reset) is set
// per cycle. A transaction-level model predicts ready each cycle and pushes
// the expected registered outputs for the following cycle into a queue that
// an independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_jtag_player_arbiter;

    localparam int HW = 1016;
    localparam int DT = 16;
    localparam int RC = 8;

    typedef struct packed {
        logic       rst;
        logic       full;
        logic [9:0] cnt;
        logic       eof;
        logic       err;
        logic       holdA;
        logic       holdB;
    } env_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } item_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] data;
        logic       ad;
        logic       ae;
        logic       bd;
        logic       be;
        logic       frst;
        logic       busy;
        logic       own;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
    logic       a_ready, a_done, a_err, b_ready, b_done, b_err;
    logic [7:0] fifo_data;
    logic       fifo_wr_en, fifo_rst, busy, owner;
    logic       full_fifo = 1'b0, empty_fifo = 1'b1;
    logic [9:0] wr_data_count = '0;
    logic       eof_in = 1'b0, error_in = 1'b0;

    always #5 clk = ~clk;

    jtag_player_arbiter #(
        .HIGH_WATER    (HW),
        .DRAIN_TIMEOUT (DT),
        .RST_CYCLES    (RC)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .a_data        (a_data),
        .a_valid       (a_valid),
        .a_last        (a_last),
        .a_ready       (a_ready),
        .a_done        (a_done),
        .a_err         (a_err),
        .b_data        (b_data),
        .b_valid       (b_valid),
        .b_last        (b_last),
        .b_ready       (b_ready),
        .b_done        (b_done),
        .b_err         (b_err),
        .fifo_data     (fifo_data),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_rst      (fifo_rst),
        .full_fifo     (full_fifo),
        .empty_fifo    (empty_fifo),
        .wr_data_count (wr_data_count),
        .eof_in        (eof_in),
        .error_in      (error_in),
        .busy          (busy),
        .owner         (owner)
    );

    item_t srcA[$];
    item_t srcB[$];
    exp_t  expQ[$];

    int checks = 0;
    int errors = 0;
    int writesSeen = 0;
    int aDoneSeen = 0, aErrSeen = 0, bDoneSeen = 0, bErrSeen = 0;
    int frstSeen = 0;

    // Model of the shared player: who holds it, whether the holder has sent
    // its last byte and how long it has waited for eof, and how many reset
    // cycles remain after an abort.
    bit mHeld = 0;
    bit mLastSent = 0;
    bit mOwner = 0;
    bit mRr = 1;
    int mWait = 0;
    int mAbortLeft = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic env_t quiet();
        env_t e;
        e = '0;
        return e;
    endfunction

    task automatic loadA(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            item_t it;
            it.data = first + 8'(i);
            it.last = (i == n - 1);
            srcA.push_back(it);
        end
    endtask

    task automatic loadB(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            item_t it;
            it.data = first + 8'(i);
            it.last = (i == n - 1);
            srcB.push_back(it);
        end
    endtask

    function automatic void startAbort(ref exp_t x);
        x.ae = (mOwner == 1'b0);
        x.be = (mOwner == 1'b1);
        mHeld = 0;
        mLastSent = 0;
        mAbortLeft = RC;
    endfunction

    // One clock cycle: drive inputs, check ready against the model, advance
    // the model and queue what the registered outputs should show next.
    task automatic applyStimulus(input env_t e);
        item_t ia, ib;
        bit    va, vb, ra, rb, accA, accB;
        exp_t  x;
        @(posedge clk);
        #2;
        va = (srcA.size() > 0) && !e.holdA;
        vb = (srcB.size() > 0) && !e.holdB;
        ia = (srcA.size() > 0) ? srcA[0] : '0;
        ib = (srcB.size() > 0) ? srcB[0] : '0;
        rst_in        = e.rst;
        full_fifo     = e.full;
        wr_data_count = e.cnt;
        eof_in        = e.eof;
        error_in      = e.err;
        a_valid       = va;
        a_data        = ia.data;
        a_last        = ia.last;
        b_valid       = vb;
        b_data        = ib.data;
        b_last        = ib.last;
        empty_fifo    = 1'($urandom_range(0, 1));
        #2;
        ra = !e.rst && (mAbortLeft == 0) && mHeld && !mLastSent && (mOwner == 1'b0)
             && !e.full && (int'(e.cnt) < HW);
        rb = !e.rst && (mAbortLeft == 0) && mHeld && !mLastSent && (mOwner == 1'b1)
             && !e.full && (int'(e.cnt) < HW);
        checkOutput("a_ready", 32'(a_ready), 32'(ra));
        checkOutput("b_ready", 32'(b_ready), 32'(rb));
        accA = ra && va;
        accB = rb && vb;
        x = '0;
        if (accA) begin
            x.wr = 1'b1;
            x.data = ia.data;
            void'(srcA.pop_front());
        end
        if (accB) begin
            x.wr = 1'b1;
            x.data = ib.data;
            void'(srcB.pop_front());
        end
        if (e.rst) begin
            mHeld = 0;
            mLastSent = 0;
            mAbortLeft = 0;
            mRr = 1;
            mOwner = 0;
            x.frst = 1'b1;
        end else if (mAbortLeft > 0) begin
            mAbortLeft--;
        end else if (!mHeld) begin
            if (va || vb) begin
                mOwner = (va && vb) ? !mRr : vb;
                mRr = mOwner;
                mHeld = 1;
                mLastSent = 0;
            end
        end else if (!mLastSent) begin
            if (e.err) begin
                startAbort(x);
            end else if ((accA && ia.last) || (accB && ib.last)) begin
                mLastSent = 1;
                mWait = 0;
            end
        end else begin
            if (e.err) begin
                startAbort(x);
            end else if (e.eof) begin
                x.ad = (mOwner == 1'b0);
                x.bd = (mOwner == 1'b1);
                mHeld = 0;
                mLastSent = 0;
            end else if (mWait == DT - 1) begin
                startAbort(x);
            end else begin
                mWait++;
            end
        end
        x.busy = mHeld || (mAbortLeft > 0);
        x.frst = x.frst || (mAbortLeft > 0);
        x.own  = mOwner;
        expQ.push_back(x);
    endtask

    task automatic run(input int n, input env_t e);
        for (int i = 0; i < n; i++) begin
            applyStimulus(e);
        end
    endtask

    task automatic eofStep();
        env_t e;
        e = quiet();
        e.eof = 1'b1;
        applyStimulus(e);
    endtask

    // Monitor: compares the registered outputs one cycle after each
    // stimulus cycle against what the model queued.
    initial begin
        forever begin
            exp_t x;
            @(posedge clk);
            #1;
            writesSeen += int'(fifo_wr_en);
            aDoneSeen  += int'(a_done);
            aErrSeen   += int'(a_err);
            bDoneSeen  += int'(b_done);
            bErrSeen   += int'(b_err);
            frstSeen   += int'(fifo_rst);
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                checkOutput("fifo_wr_en", 32'(fifo_wr_en), 32'(x.wr));
                if (x.wr) checkOutput("fifo_data", 32'(fifo_data), 32'(x.data));
                checkOutput("a_done", 32'(a_done), 32'(x.ad));
                checkOutput("a_err", 32'(a_err), 32'(x.ae));
                checkOutput("b_done", 32'(b_done), 32'(x.bd));
                checkOutput("b_err", 32'(b_err), 32'(x.be));
                checkOutput("fifo_rst", 32'(fifo_rst), 32'(x.frst));
                checkOutput("busy", 32'(busy), 32'(x.busy));
                if (x.busy) checkOutput("owner", 32'(owner), 32'(x.own));
            end
        end
    end

    initial begin
        env_t e;
        int   w0, d0, r0;

        // Reset, then A alone: 0x11..0x15, eof ten cycles after the last byte.
        e = quiet();
        e.rst = 1'b1;
        run(2, e);
        w0 = writesSeen;
        d0 = aDoneSeen;
        loadA(8'h11, 5);
        run(6, quiet());
        run(9, quiet());
        eofStep();
        run(2, quiet());
        checkOutput("a_alone_writes", 32'(writesSeen - w0), 32'd5);
        checkOutput("a_alone_done", 32'(aDoneSeen - d0), 32'd1);
        $display("[TB] single stream done");

        // Tie after reset: A first, then B, then the next tie goes to A.
        e = quiet();
        e.rst = 1'b1;
        run(1, e);
        loadA(8'hA0, 2);
        loadB(8'hB0, 2);
        run(4, quiet());
        run(2, quiet());
        eofStep();
        run(3, quiet());
        loadA(8'hA8, 1);
        loadB(8'hB8, 1);
        eofStep();
        run(2, quiet());
        eofStep();
        run(2, quiet());
        eofStep();
        run(1, quiet());
        $display("[TB] round robin done");

        // High-water and full boundaries.
        w0 = writesSeen;
        loadA(8'h40, 3);
        run(1, quiet());
        e = quiet();
        e.cnt = 10'd1016;
        run(4, e);
        e.cnt = 10'd1015;
        run(1, e);
        e = quiet();
        e.full = 1'b1;
        run(3, e);
        run(2, quiet());
        eofStep();
        run(1, quiet());
        checkOutput("high_water_writes", 32'(writesSeen - w0), 32'd3);
        $display("[TB] flow control done");

        // Player error during B's stream, then error together with eof.
        r0 = bErrSeen;
        w0 = frstSeen;
        loadB(8'h60, 6);
        run(3, quiet());
        e = quiet();
        e.err = 1'b1;
        applyStimulus(e);
        srcB.delete();
        run(9, quiet());
        checkOutput("b_err_pulses", 32'(bErrSeen - r0), 32'd1);
        checkOutput("fifo_rst_width", 32'(frstSeen - w0), 32'(RC));
        d0 = bDoneSeen;
        loadB(8'h70, 2);
        run(3, quiet());
        e = quiet();
        e.err = 1'b1;
        e.eof = 1'b1;
        applyStimulus(e);
        run(10, quiet());
        checkOutput("err_beats_eof_err", 32'(bErrSeen - r0), 32'd2);
        checkOutput("err_beats_eof_done", 32'(bDoneSeen - d0), 32'd0);

        // Error in the same cycle as A's last byte: written, then aborted.
        loadA(8'h80, 1);
        run(1, quiet());
        e = quiet();
        e.err = 1'b1;
        applyStimulus(e);
        run(9, quiet());
        $display("[TB] error handling done");

        // DRAIN timeout with no eof.
        r0 = aErrSeen;
        loadA(8'h90, 1);
        run(2, quiet());
        run(30, quiet());
        checkOutput("timeout_a_err", 32'(aErrSeen - r0), 32'd1);

        // Reset in the middle of a stream after three bytes.
        loadA(8'h30, 6);
        run(4, quiet());
        e = quiet();
        e.rst = 1'b1;
        applyStimulus(e);
        srcA.delete();
        run(3, quiet());
        $display("[TB] timeout and reset done");

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if (srcA.size() == 0 && $urandom_range(0, 3) == 0)
                loadA(8'($urandom), int'($urandom_range(1, 5)));
            if (srcB.size() == 0 && $urandom_range(0, 3) == 0)
                loadB(8'($urandom), int'($urandom_range(1, 5)));
            e = quiet();
            e.cnt   = ($urandom_range(0, 9) < 2) ? 10'($urandom_range(1014, 1018))
                                                 : 10'($urandom_range(0, 1000));
            e.full  = ($urandom_range(0, 9) == 0);
            e.eof   = ($urandom_range(0, 19) == 0);
            e.err   = ($urandom_range(0, 59) == 0);
            e.rst   = ($urandom_range(0, 299) == 0);
            e.holdA = ($urandom_range(0, 5) == 0);
            e.holdB = ($urandom_range(0, 5) == 0);
            applyStimulus(e);
        end

        repeat (2) @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
